// File: rtl/hornet_com_rx.sv
// rtl/hornet_com_rx.sv - hornet link target: 4-phase req/ack capture into a FIFO drained by a rd_req/rd_ack port
// Optional build macro HORNET_COM_RX_SYNC_EN adds a 2-flop synchroniser on t_com_req.
module hornet_com_rx #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            t_com_dat,
    input  logic                     t_com_req,
    output logic                     t_com_ack,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [DW-1:0]            rd_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic {IDLE, HOLD} link_state_t;

    link_state_t     state;
    logic            req_s;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DW-1:0]   mem [DEPTH];
    logic            push;
    logic            pop;

`ifdef HORNET_COM_RX_SYNC_EN
    logic req_meta;
    logic req_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta <= 1'b0;
            req_sync <= 1'b0;
        end else begin
            req_meta <= t_com_req;
            req_sync <= req_meta;
        end
    end

    assign req_s = req_sync;
`else
    assign req_s = t_com_req;
`endif

    // A full FIFO leaves the link un-acked so the neighbour stalls instead of losing a word.
    assign push = (state == IDLE) && req_s && (level != FULL);
    assign pop  = rd_req && (level != '0) && !rd_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            t_com_ack <= 1'b0;
            wr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        wr_ptr    <= wr_ptr + AW'(1);
                        t_com_ack <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!req_s) begin
                        t_com_ack <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    t_com_ack <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= t_com_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_ack <= 1'b0;
            rd_dat <= '0;
            level  <= '0;
        end else begin
            rd_ack <= pop;
            if (pop) begin
                rd_dat <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_hornet_com_rx.sv
// tb/tb_hornet_com_rx.sv - directed bench for hornet_com_rx with a queue-based reference model
module tb_hornet_com_rx;

    localparam int DW    = 18;
    localparam int DEPTH = 4;
`ifdef HORNET_COM_RX_SYNC_EN
    localparam int ACK_LAT = 3;
    localparam bit SYNC    = 1'b1;
`else
    localparam int ACK_LAT = 1;
    localparam bit SYNC    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] t_com_dat;
    logic          t_com_req;
    logic          t_com_ack;
    logic          rd_req;
    logic          rd_ack;
    logic [DW-1:0] rd_dat;
    logic [2:0]    level;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hornet_com_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_com_dat (t_com_dat),
        .t_com_req (t_com_req),
        .t_com_ack (t_com_ack),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_dat    (rd_dat),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the FIFO is a queue, the link is "acked while the request is still seen".
    logic [DW-1:0] mq[$];
    logic          m_ack;
    logic          m_rd_ack;
    logic [DW-1:0] m_rd_dat;
    logic          s1, s2;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_ack = 1'b0; m_rd_ack = 1'b0; m_rd_dat = '0; s1 = 1'b0; s2 = 1'b0;
            end else begin
                logic seen, take, capture;
                seen    = SYNC ? s2 : t_com_req;
                take    = rd_req && (mq.size() != 0) && !m_rd_ack;
                capture = seen && !m_ack && (mq.size() < DEPTH);
                m_rd_ack = take;
                if (take) m_rd_dat = mq.pop_front();
                if (capture) mq.push_back(t_com_dat);
                m_ack = seen && (m_ack || capture);
                s2 = s1;
                s1 = t_com_req;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_ack", {31'b0, t_com_ack}, {31'b0, m_ack});
            chk("model_rd_ack", {31'b0, rd_ack}, {31'b0, m_rd_ack});
            chk("model_rd_dat", {14'b0, rd_dat}, {14'b0, m_rd_dat});
            chk("model_level", {29'b0, level}, mq.size());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic val, input string name);
        for (int i = 0; i < 20; i++) begin
            if (t_com_ack === val) break;
            cyc(1);
        end
        chk(name, {31'b0, t_com_ack}, {31'b0, val});
    endtask

    task automatic send(input logic [DW-1:0] w);
        t_com_dat = w;
        t_com_req = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        t_com_req = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic read(input logic [DW-1:0] exp, input string name);
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (rd_ack === 1'b1) break;
        end
        chk({name, "_ack"}, {31'b0, rd_ack}, 32'd1);
        chk(name, {14'b0, rd_dat}, {14'b0, exp});
        rd_req = 1'b0;
        cyc(1);
    endtask

    initial begin
        bit stalled_ok;
        reset = 1'b1; t_com_dat = '0; t_com_req = 1'b0; rd_req = 1'b0;
        cyc(3);
        chk("reset_ack", {31'b0, t_com_ack}, 32'd0);
        chk("reset_rd_ack", {31'b0, rd_ack}, 32'd0);
        chk("reset_rd_dat", {14'b0, rd_dat}, 32'd0);
        chk("reset_level", {29'b0, level}, 32'd0);
        reset = 1'b0;
        cyc(2);

        // 1: single word
        t_com_dat = 18'h05D4F;
        t_com_req = 1'b1;
        cyc(ACK_LAT - 1);
        chk("t1_ack_not_early", {31'b0, t_com_ack}, 32'd0);
        cyc(1);
        chk("t1_ack", {31'b0, t_com_ack}, 32'd1);
        chk("t1_level", {29'b0, level}, 32'd1);
        t_com_req = 1'b0;
        cyc(ACK_LAT);
        chk("t1_ack_drop", {31'b0, t_com_ack}, 32'd0);
        rd_req = 1'b1;
        cyc(1);
        chk("t1_rd_ack", {31'b0, rd_ack}, 32'd1);
        chk("t1_rd_dat", {14'b0, rd_dat}, 32'h05D4F);
        chk("t1_level0", {29'b0, level}, 32'd0);
        rd_req = 1'b0;
        cyc(1);
        chk("t1_rd_ack_pulse", {31'b0, rd_ack}, 32'd0);
        chk("t1_rd_dat_hold", {14'b0, rd_dat}, 32'h05D4F);

        // 2: fill and stall
        for (int i = 1; i <= 4; i++) send(DW'(i));
        chk("t2_full", {29'b0, level}, 32'd4);
        t_com_dat = 18'd5;
        t_com_req = 1'b1;
        stalled_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (t_com_ack !== 1'b0) stalled_ok = 1'b0;
        end
        chk("t2_stall", {31'b0, stalled_ok}, 32'd1);
        rd_req = 1'b1;
        cyc(1);
        chk("t2_rd_dat", {14'b0, rd_dat}, 32'd1);
        chk("t2_level3", {29'b0, level}, 32'd3);
        rd_req = 1'b0;
        cyc(1);
        chk("t2_late_ack", {31'b0, t_com_ack}, 32'd1);
        chk("t2_level4", {29'b0, level}, 32'd4);
        t_com_req = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");

        // 3: drain order and empty wait
        read(18'd2, "t3_w2");
        read(18'd3, "t3_w3");
        read(18'd4, "t3_w4");
        read(18'd5, "t3_w5");
        rd_req = 1'b1;
        stalled_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (rd_ack !== 1'b0) stalled_ok = 1'b0;
        end
        chk("t3_empty_wait", {31'b0, stalled_ok}, 32'd1);
        rd_req = 1'b0;
        chk("t3_level0", {29'b0, level}, 32'd0);

        // 4: push and pop on one edge
        send(18'h10);
        send(18'h11);
        t_com_dat = 18'h12;
        t_com_req = 1'b1;
        cyc(ACK_LAT - 1);
        rd_req = 1'b1;
        cyc(1);
        chk("t4_ack", {31'b0, t_com_ack}, 32'd1);
        chk("t4_rd_ack", {31'b0, rd_ack}, 32'd1);
        chk("t4_oldest", {14'b0, rd_dat}, 32'h10);
        chk("t4_level", {29'b0, level}, 32'd2);
        rd_req = 1'b0;
        t_com_req = 1'b0;
        wait_ack(1'b0, "t4_ack_fall");
        read(18'h11, "t4_w11");
        read(18'h12, "t4_w12");

        // 5: held request captures once
        t_com_dat = 18'h20;
        t_com_req = 1'b1;
        wait_ack(1'b1, "t5_ack");
        t_com_dat = 18'h21;
        cyc(8);
        chk("t5_level", {29'b0, level}, 32'd1);
        t_com_req = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        chk("t5_level_after", {29'b0, level}, 32'd1);
        read(18'h20, "t5_w20");

        // 6: reset mid-handshake
        send(18'h30);
        send(18'h31);
        t_com_dat = 18'h32;
        t_com_req = 1'b1;
        wait_ack(1'b1, "t6_ack");
        chk("t6_level3", {29'b0, level}, 32'd3);
        reset = 1'b1;
        #1;
        chk("t6_rst_ack", {31'b0, t_com_ack}, 32'd0);
        chk("t6_rst_level", {29'b0, level}, 32'd0);
        chk("t6_rst_rd_ack", {31'b0, rd_ack}, 32'd0);
        cyc(2);
        reset = 1'b0;
        wait_ack(1'b1, "t6_recapture");
        cyc(5);
        chk("t6_level1", {29'b0, level}, 32'd1);
        t_com_req = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        read(18'h32, "t6_w32");
        chk("t6_level0", {29'b0, level}, 32'd0);

        cyc(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
